// File: rtl/fsm_leer_rtc_multi_pkg.sv
// Shared types and constants for the RTC burst reader.
package fsm_leer_rtc_multi_pkg;

  localparam int RTC_DATA_W   = 8;
  localparam int RTC_NUM_REGS = 6;

  // Index 0 sits in the LSBs: seconds..year style register map at 0x21..0x26.
  localparam logic [RTC_NUM_REGS*RTC_DATA_W-1:0] RTC_DEF_ADDRS =
    {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_R_SETUP  = 4'd4,
    ST_R_STROBE = 4'd5,
    ST_R_HOLD   = 4'd6,
    ST_RAM_WR   = 4'd7,
    ST_FIN      = 4'd8
  } rtc_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fsm_leer_rtc_multi_bus_phase.sv
// Bus phase timer: loaded with a sub-phase length, flags the final cycle of that sub-phase.
module fsm_leer_rtc_multi_bus_phase #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] len_i,
  output logic          phase_done_o
);

  logic [CW-1:0] cnt_q;

  // Down-counter; a value of 1 marks the last cycle of the current sub-phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= len_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign phase_done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/fsm_leer_rtc_multi.sv
// RTC burst reader: reads each masked RTC register over the multiplexed bus and
// copies the byte into display RAM at RAM_BASE+index.
module fsm_leer_rtc_multi
  import fsm_leer_rtc_multi_pkg::*;
#(
  parameter int                         NUM_REGS  = RTC_NUM_REGS,
  parameter int                         DATA_W    = RTC_DATA_W,
  parameter int                         RAM_AW    = 4,
  parameter int                         RAM_BASE  = 0,
  parameter logic [NUM_REGS*DATA_W-1:0] REG_ADDRS = RTC_DEF_ADDRS,
  parameter int                         T_SETUP   = 1,
  parameter int                         T_STROBE  = 4,
  parameter int                         T_HOLD    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_mask,
  output logic                busy,
  output logic                done,
  output logic                a_d,
  output logic                cs,
  output logic                rd,
  output logic                wr,
  output logic [DATA_W-1:0]   ad_out,
  output logic                ad_oe,
  input  logic [DATA_W-1:0]   ad_in,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata
);

  localparam int CW = $clog2(max3(T_SETUP, T_STROBE, T_HOLD) + 1);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  rtc_state_e          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]   byte_q, byte_d;
  logic                tmr_load_s;
  logic [CW-1:0]       tmr_len_s;
  logic                phase_done_s;
  logic [IW:0]         first_s, next_s;
  logic                addr_ph_s;

  logic                busy_q, done_q, a_d_q, cs_q, rd_q, wr_q, ad_oe_q, ram_we_q;
  logic                busy_d, done_d, a_d_d, cs_d, rd_d, wr_d, ad_oe_d, ram_we_d;
  logic [DATA_W-1:0]   ad_out_q, ad_out_d, ram_wdata_q, ram_wdata_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;

  // Lowest set bit at or above 'from'; MSB of the result flags that one was found.
  function automatic logic [IW:0] scan_from(input logic [NUM_REGS-1:0] m, input int from);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        r = {1'b1, IW'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign first_s = scan_from(reg_mask, 0);
  assign next_s  = scan_from(mask_q, int'(idx_q) + 1);

  fsm_leer_rtc_multi_bus_phase #(.CW(CW)) u_phase (
    .clk          (clk),
    .reset        (reset),
    .load_i       (tmr_load_s),
    .len_i        (tmr_len_s),
    .phase_done_o (phase_done_s)
  );

  // Next-state logic; every timed state loads the timer for the state it enters.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    byte_d     = byte_q;
    tmr_load_s = 1'b0;
    tmr_len_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = reg_mask;
          if (first_s[IW]) begin
            idx_d      = first_s[IW-1:0];
            state_d    = ST_A_SETUP;
            tmr_load_s = 1'b1;
            tmr_len_s  = CW'(T_SETUP);
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_A_SETUP: begin
        if (phase_done_s) begin
          state_d    = ST_A_STROBE;
          tmr_load_s = 1'b1;
          tmr_len_s  = CW'(T_STROBE);
        end else begin
          state_d = ST_A_SETUP;
        end
      end
      ST_A_STROBE: begin
        if (phase_done_s) begin
          state_d    = ST_A_HOLD;
          tmr_load_s = 1'b1;
          tmr_len_s  = CW'(T_HOLD);
        end else begin
          state_d = ST_A_STROBE;
        end
      end
      ST_A_HOLD: begin
        if (phase_done_s) begin
          state_d    = ST_R_SETUP;
          tmr_load_s = 1'b1;
          tmr_len_s  = CW'(T_SETUP);
        end else begin
          state_d = ST_A_HOLD;
        end
      end
      ST_R_SETUP: begin
        if (phase_done_s) begin
          state_d    = ST_R_STROBE;
          tmr_load_s = 1'b1;
          tmr_len_s  = CW'(T_STROBE);
        end else begin
          state_d = ST_R_SETUP;
        end
      end
      ST_R_STROBE: begin
        if (phase_done_s) begin
          byte_d     = ad_in;
          state_d    = ST_R_HOLD;
          tmr_load_s = 1'b1;
          tmr_len_s  = CW'(T_HOLD);
        end else begin
          state_d = ST_R_STROBE;
        end
      end
      ST_R_HOLD: begin
        if (phase_done_s) begin
          state_d = ST_RAM_WR;
        end else begin
          state_d = ST_R_HOLD;
        end
      end
      ST_RAM_WR: begin
        if (next_s[IW]) begin
          idx_d      = next_s[IW-1:0];
          state_d    = ST_A_SETUP;
          tmr_load_s = 1'b1;
          tmr_len_s  = CW'(T_SETUP);
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so the registered pins line up with it.
  always_comb begin
    addr_ph_s = (state_d == ST_A_SETUP) || (state_d == ST_A_STROBE) || (state_d == ST_A_HOLD);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d    = (state_d == ST_FIN);
    a_d_d     = !addr_ph_s;
    ad_oe_d   = addr_ph_s;
    wr_d      = (state_d != ST_A_STROBE);
    rd_d      = (state_d != ST_R_STROBE);
    cs_d      = wr_d && rd_d;
    ram_we_d  = (state_d == ST_RAM_WR);
    if (addr_ph_s) begin
      ad_out_d = REG_ADDRS[int'(idx_d)*DATA_W +: DATA_W];
    end else begin
      ad_out_d = '0;
    end
    if (ram_we_d) begin
      ram_addr_d  = RAM_AW'(RAM_BASE) + RAM_AW'(idx_d);
      ram_wdata_d = byte_d;
    end else begin
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
    end
  end

  // State, datapath and output registers; reset releases every strobe at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      byte_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_d_q       <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      byte_q      <= byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_d_q       <= a_d_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_d       = a_d_q;
  assign cs        = cs_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign ad_oe     = ad_oe_q;
  assign ad_out    = ad_out_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
